pattern_1xx0_gen: RTL

- Serial frame transmitter for the 1XX0 pattern channel: takes a 2-bit payload over a valid/ready handshake and emits the 4-bit frame 1, d[1], d[0], 0 MSB-first on a single serial line.
- It drives the `x` input of the 1XX0 sequence detector. A 1-entry holding buffer allows back-to-back frames with no bubbles.
- Configurable idle-zero gap between frames.

---
 rtl/pattern_pkg.sv | 23 ++
 rtl/pattern_hold_buf.sv | 33 +++
 rtl/pattern_1xx0_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared encoding for the 1XX0 pattern channel: FSM states and frame constants
// used by the generator and the detector.
package pattern_pkg;

  // Each state names the bit carried on the serial line during that cycle.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B1   = 3'd1,
    BD1  = 3'd2,
    BD0  = 3'd3,
    B0   = 3'd4,
    GAPW = 3'd5
  } state_t;

  localparam int   FRAME_LEN = 4;
  localparam logic HDR       = 1'b1;
  localparam logic TRL       = 1'b0;

  function automatic logic is_frame_bit(input state_t s);
    return (s == B1) || (s == BD1) || (s == BD0) || (s == B0);
  endfunction

endpackage

// File: rtl/pattern_hold_buf.sv
// One-entry holding register between the payload handshake and the frame FSM.
// Transfer: in_valid && in_ready at a rising edge; in_ready means the entry is empty.
module pattern_hold_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_data,
  input  logic       take,
  output logic       in_ready,
  output logic       full,
  output logic [1:0] data,
  output logic       full_next
);

  logic accept;

  // Forced low while reset is held so no transfer can be claimed during reset.
  assign in_ready  = rst && !full;
  assign accept    = in_valid && in_ready;
  // take only happens while full and accept only while empty, so they never collide.
  assign full_next = accept || (full && !take);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      data <= 2'b00;
    end else begin
      full <= full_next;
      if (accept) data <= in_data;
    end
  end

endmodule

// File: rtl/pattern_1xx0_gen.sv
// Serial 1XX0 frame transmitter: emits 1,d1,d0,0 per payload with GAP idle cycles after each frame.
// Define PAT_GEN_FRAME_CNT_EN to add the 16-bit wrapping frame_cnt output.
module pattern_1xx0_gen
  import pattern_pkg::*;
#(
  parameter int GAP   = 0,
  parameter int GAP_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_data,
  output logic       in_ready,
  output logic       y,
  output logic       y_valid,
  output logic       frame_done,
  output logic       busy
`ifdef PAT_GEN_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  state_t             state_q, state_d;
  logic   [1:0]       shift_q, shift_d;
  logic   [GAP_W-1:0] gap_q, gap_d;
  logic               take;
  logic               buf_full, buf_full_next;
  logic   [1:0]       buf_data;
  logic               y_d, y_valid_d, frame_done_d, busy_d;

  pattern_hold_buf u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .take      (take),
    .in_ready  (in_ready),
    .full      (buf_full),
    .data      (buf_data),
    .full_next (buf_full_next)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    gap_d   = gap_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (buf_full) begin
          state_d = B1;
          shift_d = buf_data;
          take    = 1'b1;
        end
      end
      B1:  state_d = BD1;
      BD1: state_d = BD0;
      BD0: state_d = B0;
      B0: begin
        if (GAP > 0) begin
          state_d = GAPW;
          gap_d   = GAP_W'(GAP);
        end else if (buf_full) begin
          // Back-to-back: next header follows the trailer with no bubble.
          state_d = B1;
          shift_d = buf_data;
          take    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GAPW: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          gap_d = '0;
          if (buf_full) begin
            state_d = B1;
            shift_d = buf_data;
            take    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered alongside it.
  always_comb begin
    y_d = 1'b0;
    case (state_d)
      B1:      y_d = HDR;
      BD1:     y_d = shift_d[1];
      BD0:     y_d = shift_d[0];
      B0:      y_d = TRL;
      default: y_d = 1'b0;
    endcase
    y_valid_d    = is_frame_bit(state_d);
    frame_done_d = (state_d == B0);
    busy_d       = (state_d != IDLE) || buf_full_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= 2'b00;
      gap_q      <= '0;
      y          <= 1'b0;
      y_valid    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      gap_q      <= gap_d;
      y          <= y_d;
      y_valid    <= y_valid_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
    end
  end

`ifdef PAT_GEN_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_cnt <= 16'h0000;
    else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule
